paleta_cpu: RTL and testbench



---
 rtl/paleta_cpu.sv | 125 ++++++++++++
 tb/tb_paleta_cpu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/paleta_cpu.sv
// paleta_cpu: computer opponent for a Pong paddle. It emits active-low
// up/down presses that steer the paddle toward the ball. A tick divider
// limits how often it decides, and a reaction delay keeps it beatable.
module paleta_cpu #(
  parameter int TICK_DIV_BITS = 17,
  parameter int PADDLE_H      = 100,
  parameter int DEAD_ZONE     = 4,
  parameter int REACT_TICKS   = 8,
  parameter int Y_MIN         = 10,
  parameter int Y_MAX         = 370,
  parameter int Y_CENTER      = 220
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] ball_y,
  input  logic       ball_toward,
  input  logic [9:0] paddle_y,
  output logic       puls_up_n,
  output logic       puls_down_n,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REACT = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  localparam logic signed [10:0] HALF_H   = 11'(PADDLE_H / 2);
  localparam logic signed [10:0] DZ       = 11'(DEAD_ZONE);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);
  localparam logic signed [10:0] YCTR_S   = 11'(Y_CENTER);
  localparam logic [7:0]         REACT_N  = 8'(REACT_TICKS);

  logic [TICK_DIV_BITS-1:0] div_q, div_d;
  state_t                   state_q, state_d;
  logic [7:0]               react_q, react_d;
  logic                     up_q, up_d, dn_q, dn_d;
  logic                     tick;
  logic signed [10:0]       track_raw, track_tgt;

  // Map a target top-y to the button pair {up_n, down_n}; the two presses are
  // mutually exclusive because err cannot be both below and above the zone.
  function automatic logic [1:0] steer(input logic signed [10:0] tgt,
                                       input logic [9:0] py);
    logic signed [10:0] err;
    err = tgt - $signed({1'b0, py});
    if (err < -DZ)     steer = 2'b01;
    else if (err > DZ) steer = 2'b10;
    else               steer = 2'b11;
  endfunction

  assign tick = &div_q;

  // Ball-centred target, signed so a ball near the top clamps instead of wrapping
  always_comb begin
    track_raw = $signed({1'b0, ball_y}) - HALF_H;
    track_tgt = track_raw;
    if (track_raw < YMIN_S)      track_tgt = YMIN_S;
    else if (track_raw > YMAX_S) track_tgt = YMAX_S;
  end

  // Next-state and registered button decisions; abort to IDLE has top priority
  always_comb begin
    div_d   = div_q + 1'b1;
    state_d = state_q;
    react_d = react_q;
    up_d    = up_q;
    dn_d    = dn_q;
    if (!enable) begin
      state_d = S_IDLE;
      up_d    = 1'b1;
      dn_d    = 1'b1;
    end else if (!ball_toward) begin
      state_d = S_IDLE;
      if (tick) {up_d, dn_d} = steer(YCTR_S, paddle_y);
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REACT;
          react_d = 8'd0;
          up_d    = 1'b1;
          dn_d    = 1'b1;
        end
        S_REACT: begin
          if (tick) begin
            react_d = react_q + 8'd1;
            if (react_d == REACT_N) begin
              state_d      = S_TRACK;
              {up_d, dn_d} = steer(track_tgt, paddle_y);
            end
          end
        end
        S_TRACK: begin
          if (tick) {up_d, dn_d} = steer(track_tgt, paddle_y);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; presses never survive reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      state_q <= S_IDLE;
      react_q <= 8'd0;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      react_q <= react_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  assign puls_up_n   = up_q;
  assign puls_down_n = dn_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_paleta_cpu.sv
// Scoreboard bench for paleta_cpu: the driver updates a behavioural model on
// every edge and queues the expected outputs; a monitor on the falling edge
// pops and compares against the DUT.
module tb_paleta_cpu;
  localparam int TDB = 2;
  localparam int RT  = 3;
  localparam int PER = 1 << TDB;

  logic       clk = 1'b0;
  logic       rst, enable, ball_toward;
  logic [9:0] ball_y, paddle_y;
  logic       puls_up_n, puls_down_n;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [3:0] sb[$];

  // Model state: cycles since reset, mode 0/1/2, ticks spent reacting, buttons
  int   m_cyc, m_mode, m_ticks;
  logic m_up, m_dn;

  paleta_cpu #(.TICK_DIV_BITS(TDB), .REACT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ball_y(ball_y),
    .ball_toward(ball_toward), .paddle_y(paddle_y),
    .puls_up_n(puls_up_n), .puls_down_n(puls_down_n), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] decide(input int target, input int py);
    int e;
    e = target - py;
    if (e < -4) return 2'b01;
    if (e > 4)  return 2'b10;
    return 2'b11;
  endfunction

  function automatic int ball_target(input int by);
    int t;
    t = by - 50;
    if (t < 10)  t = 10;
    if (t > 370) t = 370;
    return t;
  endfunction

  // One clock: inputs are applied, the edge happens, the model follows suit
  task automatic cyc(input logic r, input logic e, input logic tw,
                     input int by, input int py);
    bit tk;
    rst = r; enable = e; ball_toward = tw;
    ball_y = 10'(by); paddle_y = 10'(py);
    @(posedge clk);
    if (r) begin
      m_cyc = 0; m_mode = 0; m_ticks = 0; m_up = 1; m_dn = 1;
    end else begin
      tk = (m_cyc % PER) == PER - 1;
      m_cyc++;
      if (!e) begin
        m_mode = 0; m_up = 1; m_dn = 1;
      end else if (!tw) begin
        m_mode = 0;
        if (tk) {m_up, m_dn} = decide(220, py);
      end else if (m_mode == 0) begin
        m_mode = 1; m_ticks = 0; m_up = 1; m_dn = 1;
      end else if (m_mode == 1) begin
        if (tk) begin
          m_ticks++;
          if (m_ticks == RT) begin
            m_mode = 2;
            {m_up, m_dn} = decide(ball_target(by), py);
          end
        end
      end else if (tk) begin
        {m_up, m_dn} = decide(ball_target(by), py);
      end
    end
    sb.push_back({m_up, m_dn, 2'(m_mode)});
    @(negedge clk);
  endtask

  // Monitor: compare registered outputs mid-cycle, plus the no-double-press rule
  always @(negedge clk) begin
    logic [3:0] exp;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      total++;
      if ({puls_up_n, puls_down_n, state_dbg} !== exp) begin
        bad++;
        $display("FAIL outputs t=%0t got up_n=%b dn_n=%b st=%0d want up_n=%b dn_n=%b st=%0d",
                 $time, puls_up_n, puls_down_n, state_dbg, exp[3], exp[2], exp[1:0]);
      end
      total++;
      if (!(puls_up_n | puls_down_n)) begin
        bad++;
        $display("FAIL both_pressed t=%0t got up_n=%b dn_n=%b want at least one 1",
                 $time, puls_up_n, puls_down_n);
      end
    end
  end

  initial begin
    logic e, tw, r;
    int   by, py;
    rst = 1; enable = 0; ball_toward = 0; ball_y = 0; paddle_y = 0;
    m_cyc = 0; m_mode = 0; m_ticks = 0; m_up = 1; m_dn = 1;
    @(negedge clk);
    repeat (2) cyc(1, 0, 0, 0, 0);
    // IDLE centring: paddle low on screen pushes up, then settles in dead zone
    repeat (4) cyc(0, 1, 0, 100, 300);
    repeat (4) cyc(0, 1, 0, 100, 222);
    // Reaction delay then tracking toward 50
    repeat (16) cyc(0, 1, 1, 100, 220);
    // Clamp at the top (no wrap) and at the bottom
    repeat (8) cyc(0, 1, 1, 20, 10);
    repeat (8) cyc(0, 1, 1, 479, 10);
    // Enable drops with a press held, mid-period
    cyc(0, 0, 1, 479, 10);
    repeat (2) cyc(0, 0, 1, 479, 10);
    // Back to tracking with a press, then reset mid-TRACK
    repeat (18) cyc(0, 1, 1, 479, 10);
    cyc(1, 1, 1, 479, 10);
    repeat (8) cyc(0, 1, 0, 479, 10);
    // Ball turning away mid-TRACK
    repeat (20) cyc(0, 1, 1, 400, 50);
    repeat (6) cyc(0, 1, 0, 400, 50);
    // Random sweep
    e = 1; tw = 1; by = 240; py = 220;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(49) == 0) e = ~e;
      if ($urandom_range(29) == 0) tw = ~tw;
      if ($urandom_range(3) == 0) by = $urandom_range(1023);
      if ($urandom_range(3) == 0) py = $urandom_range(1023);
      r = ($urandom_range(999) == 0);
      cyc(r, e, tw, by, py);
    end
    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
